// File: rtl/bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order through a ping-pong pair of 2^N-entry banks.
// Output j of a frame is registered 1+j cycles after its last input sample; no backpressure.
module bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_ip,
  input  logic [W-1:0] ip_re,
  input  logic [W-1:0] ip_im,
  output logic [W-1:0] op_re,
  output logic [W-1:0] op_im,
  output logic         op_valid,
  output logic         start_op,
  output logic         frame_err
);

  localparam int DEPTH = 1 << N;

  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

  logic [2*W-1:0] mem [2*DEPTH];

  logic           wr_active;
  logic           wr_bank;
  logic [N-1:0]   wr_cnt;
  logic           wr_en;
  logic [N-1:0]   wr_addr;
  logic           handoff;

  rd_state_t      rd_state_q, rd_state_d;
  logic [N-1:0]   rd_cnt_q, rd_cnt_d;
  logic           rd_bank_q, rd_bank_d;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // start_ip always wins: it either opens a frame or restarts the current one at k=0.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    handoff = 1'b0;
    if (start_ip) begin
      wr_en = 1'b1;
    end else if (wr_active) begin
      wr_en   = 1'b1;
      wr_addr = bitrev(wr_cnt);
      handoff = (wr_cnt == {N{1'b1}});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_active <= 1'b0;
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= start_ip && wr_active;
      if (start_ip) begin
        wr_active <= 1'b1;
        wr_cnt    <= N'(1);
      end else if (handoff) begin
        wr_active <= 1'b0;
        wr_cnt    <= '0;
        wr_bank   <= ~wr_bank;
      end else if (wr_active) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= {ip_re, ip_im};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Equal rates mean a handoff can only coincide with the final read of a drain.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (handoff) begin
          rd_state_d = RD_DRAIN;
          rd_cnt_d   = '0;
          rd_bank_d  = wr_bank;
        end
      end
      RD_DRAIN: begin
        if (rd_cnt_q == {N{1'b1}}) begin
          rd_cnt_d = '0;
          if (handoff) rd_bank_d = wr_bank;
          else         rd_state_d = RD_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_re    <= '0;
      op_im    <= '0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
    end else begin
      op_valid <= (rd_state_q == RD_DRAIN);
      start_op <= (rd_state_q == RD_DRAIN) && (rd_cnt_q == '0);
      if (rd_state_q == RD_DRAIN) {op_re, op_im} <= mem[{rd_bank_q, rd_cnt_q}];
    end
  end

endmodule
